// File: rtl/dcache_pkg.sv
// Shared types and address-field sizing helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int num_sets, input int line_words);
    return addr_width - 2 - $clog2(num_sets) - $clog2(line_words);
  endfunction

  localparam int WORD_BITS  = word_bits(4);
  localparam int INDEX_BITS = index_bits(16);
  localparam int TAG_BITS   = tag_bits(32, 16, 4);

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
    logic [WORD_BITS-1:0]  word;
  } line_addr_t;

endpackage

// File: rtl/dcache_way.sv
// One cache way: valid/tag/data arrays with combinational lookup, fill-write and byte-enabled store-write.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = 24,
  parameter int INDEX_W    = 4,
  parameter int WORD_W     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_W-1:0]    rd_index,
  input  logic [WORD_W-1:0]     rd_word,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  hit,
  output logic                  line_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  fill_we,
  input  logic [INDEX_W-1:0]    fill_index,
  input  logic [WORD_W-1:0]     fill_word,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  fill_done,
  input  logic [TAG_W-1:0]      fill_tag,
  input  logic                  store_we,
  input  logic [3:0]            store_be,
  input  logic [DATA_WIDTH-1:0] store_data
);

  logic [NUM_SETS-1:0]   valid_reg;
  logic [TAG_W-1:0]      tag_mem  [NUM_SETS];
  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][LINE_WORDS];

  assign line_valid = valid_reg[rd_index];
  assign hit        = valid_reg[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_data    = data_mem[rd_index][rd_word];

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
    end else if (fill_done) begin
      valid_reg[fill_index] <= 1'b1;
    end
  end

  // Tag and data contents survive reset; only the valid bits are cleared.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_index] <= fill_tag;
    end
    if (fill_we) begin
      data_mem[fill_index][fill_word] <= fill_data;
    end
    if (store_we) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) begin
          data_mem[rd_index][rd_word][8*b +: 8] <= store_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache_wt.sv
// Set-associative write-through, no-write-allocate data cache with a handshaked backing-memory port.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SETS   = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [3:0]            req_be,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  stall,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WB  = word_bits(LINE_WORDS);
  localparam int IB  = index_bits(NUM_SETS);
  localparam int TB  = tag_bits(ADDR_WIDTH, NUM_SETS, LINE_WORDS);
  localparam int WBX = (WB > 0) ? WB : 1;
  localparam int CW  = WB + 1;

  logic [WBX-1:0] req_word;
  logic [IB-1:0]  req_index;
  logic [TB-1:0]  req_tag;
  logic           unused_offset;

  state_t         state_reg, state_next;
  logic           victim_reg, victim_next;
  logic [IB-1:0]  fidx_reg;
  logic [TB-1:0]  ftag_reg;
  logic [CW-1:0]  iss_reg, rcv_reg;
  logic [NUM_SETS-1:0] lru_reg;

  logic [WAYS-1:0]       way_hit, way_valid;
  logic [DATA_WIDTH-1:0] way_rdata [WAYS];
  logic                  hit, hit_way;
  logic                  lru_upd, store_we, fill_we, fill_done;
  logic [ADDR_WIDTH-1:0] fill_addr;

  assign req_index     = req_addr[WB+IB+1:WB+2];
  assign req_tag       = req_addr[ADDR_WIDTH-1:WB+IB+2];
  assign unused_offset = ^req_addr[1:0];

  generate
    if (WB > 0) begin : g_word
      assign req_word  = req_addr[WB+1:2];
      assign fill_addr = {ftag_reg, fidx_reg, iss_reg[WB-1:0], 2'b00};
    end else begin : g_noword
      assign req_word  = '0;
      assign fill_addr = {ftag_reg, fidx_reg, 2'b00};
    end
  endgenerate

  // Lookup and victim choice: lowest invalid way wins, else the lru way.
  always_comb begin
    hit         = 1'b0;
    hit_way     = 1'b0;
    rdata       = '0;
    victim_next = (WAYS == 2) ? lru_reg[req_index] : 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) begin
        hit     = 1'b1;
        hit_way = 1'(w);
        rdata   = way_rdata[w];
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) victim_next = 1'(w);
    end
  end

  always_comb begin
    state_next    = state_reg;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_be        = '0;
    mem_wdata     = '0;
    lru_upd       = 1'b0;
    store_we      = 1'b0;
    fill_we       = 1'b0;
    fill_done     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_we) begin
            stall      = 1'b1;
            store_we   = hit;
            lru_upd    = hit;
            state_next = WRITE;
          end else if (hit) begin
            lru_upd = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        stall         = 1'b1;
        mem_req_valid = (iss_reg < CW'(LINE_WORDS));
        mem_addr      = fill_addr;
        if (mem_rvalid) begin
          fill_we = 1'b1;
          if (rcv_reg == CW'(LINE_WORDS - 1)) begin
            fill_done  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req_valid = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = req_addr;
        mem_be        = req_be;
        mem_wdata     = req_wdata;
        stall         = !mem_req_ready;
        if (mem_req_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      lru_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (lru_upd) lru_reg[req_index] <= ~hit_way;
    end
  end

  // Fill bookkeeping is re-initialised on every miss, so it needs no reset.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && state_next == FILL) begin
      victim_reg <= victim_next;
      fidx_reg   <= req_index;
      ftag_reg   <= req_tag;
      iss_reg    <= '0;
      rcv_reg    <= '0;
    end else if (state_reg == FILL) begin
      if (mem_req_valid && mem_req_ready) iss_reg <= iss_reg + 1'b1;
      if (fill_we) rcv_reg <= rcv_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      dcache_way #(
        .NUM_SETS   (NUM_SETS),
        .LINE_WORDS (LINE_WORDS),
        .DATA_WIDTH (DATA_WIDTH),
        .TAG_W      (TB),
        .INDEX_W    (IB),
        .WORD_W     (WBX)
      ) u_way (
        .clk        (clk),
        .rst        (rst),
        .rd_index   (req_index),
        .rd_word    (req_word),
        .rd_tag     (req_tag),
        .hit        (way_hit[gi]),
        .line_valid (way_valid[gi]),
        .rd_data    (way_rdata[gi]),
        .fill_we    (fill_we && (victim_reg == 1'(gi))),
        .fill_index (fidx_reg),
        .fill_word  (rcv_reg[WBX-1:0]),
        .fill_data  (mem_rdata),
        .fill_done  (fill_done && (victim_reg == 1'(gi))),
        .fill_tag   (ftag_reg),
        .store_we   (store_we && way_hit[gi]),
        .store_be   (req_be),
        .store_data (req_wdata)
      );
    end
  endgenerate

endmodule

// File: tb/tb_dcache_wt.sv
// Directed self-checking bench for dcache_wt with a behavioural backing memory.
module tb_dcache_wt;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata, rdata;
  logic [3:0]  req_be;
  logic        stall, mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int ready_mode = 0;
  int wait_cnt = 0;
  logic tog = 1'b0;
  logic rv_q = 1'b0;
  logic [31:0] rd_q = '0;
  logic inj = 1'b0;

  logic [31:0] fill_log[$];
  logic [31:0] mem_img [logic [31:0]];
  int wr_cnt = 0;
  logic [31:0] last_waddr, last_wdata;
  logic [3:0]  last_wbe;
  int wstall = 0;
  int viol = 0;
  logic prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  assign mem_req_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? (wait_cnt >= 3) : tog;
  assign mem_rvalid    = rv_q | inj;
  assign mem_rdata     = inj ? 32'hBAD0_BAD0 : rd_q;

  dcache_wt dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_be        (req_be),
    .req_wdata     (req_wdata),
    .rdata         (rdata),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  function automatic logic [31:0] img(input logic [31:0] a);
    if (mem_img.exists(a)) return mem_img[a];
    return 32'hA0 + (a >> 2) - 32'h40;
  endfunction

  // Backing memory: accepts on handshake, answers a fill beat one cycle later.
  always @(posedge clk) begin : mem_model
    logic [31:0] o;
    rv_q <= 1'b0;
    tog  <= ~tog;
    if (mem_req_valid && mem_req_ready) begin
      wait_cnt <= 0;
      if (!mem_we) begin
        fill_log.push_back(mem_addr);
        rv_q <= 1'b1;
        rd_q <= img(mem_addr);
      end else begin
        o = img(mem_addr);
        for (int b = 0; b < 4; b++) if (mem_be[b]) o[8*b +: 8] = mem_wdata[8*b +: 8];
        mem_img[mem_addr] = o;
        wr_cnt     = wr_cnt + 1;
        last_waddr = mem_addr;
        last_wbe   = mem_be;
        last_wdata = mem_wdata;
      end
    end else if (mem_req_valid) begin
      wait_cnt <= wait_cnt + 1;
    end
    if (mem_req_valid && !mem_req_ready && stall && mem_we && mem_be == 4'b0011) wstall = wstall + 1;
    if (rst && prev_pend && (!mem_req_valid || mem_addr != prev_addr)) viol = viol + 1;
    prev_pend = rst && mem_req_valid && !mem_req_ready;
    prev_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal = ntotal + 1;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    $display("check %-16s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic access(input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int stalls);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
    stalls    = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!stall) break;
      stalls = stalls + 1;
    end
    if (stalls >= 400) begin
      ntotal = ntotal + 1;
      $error("FAIL timeout observed=stall expected=release addr=0x%08h", a);
    end
    rd = rdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin : stim
    logic [31:0] rd;
    int st;
    int n;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_memvalid", 32'(mem_req_valid), 32'd0);
    check("rst_memwe", 32'(mem_we), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // Cold load
    fill_log.delete();
    access(1'b0, 32'h100, 4'h0, 32'h0, rd, st);
    check("cold_rdata", rd, 32'hA0);
    check("cold_stalls", 32'(st), 32'd6);
    check("cold_nfill", 32'(fill_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < fill_log.size(); i++)
      check($sformatf("cold_faddr%0d", i), fill_log[i], 32'h100 + 32'(4 * i));
    access(1'b0, 32'h104, 4'h0, 32'h0, rd, st);
    check("hit104_stalls", 32'(st), 32'd0);
    check("hit104_rdata", rd, 32'hA1);

    // Store hit with delayed ready
    ready_mode = 1;
    access(1'b1, 32'h104, 4'b0011, 32'hDEAD_BEEF, rd, st);
    ready_mode = 0;
    check("sth_waitstall", 32'(wstall), 32'd3);
    check("sth_nwrite", 32'(wr_cnt), 32'd1);
    check("sth_waddr", last_waddr, 32'h104);
    check("sth_wbe", 32'(last_wbe), 32'h3);
    check("sth_wdata", last_wdata, 32'hDEAD_BEEF);
    access(1'b0, 32'h104, 4'h0, 32'h0, rd, st);
    check("sth_rd_stalls", 32'(st), 32'd0);
    check("sth_rd_rdata", rd, 32'h0000_BEEF);

    // Store miss: write only, then a load misses
    fill_log.delete();
    access(1'b1, 32'h2000, 4'b1111, 32'h1234_5678, rd, st);
    check("stm_nwrite", 32'(wr_cnt), 32'd2);
    check("stm_nfill", 32'(fill_log.size()), 32'd0);
    access(1'b0, 32'h2000, 4'h0, 32'h0, rd, st);
    check("stm_ld_stalls", 32'(st), 32'd6);
    check("stm_ld_rdata", rd, 32'h1234_5678);
    check("stm_ld_faddr0", (fill_log.size() > 0) ? fill_log[0] : 32'hFFFF_FFFF, 32'h2000);

    // LRU replacement in set 0
    do_reset();
    access(1'b0, 32'h000, 4'h0, 32'h0, rd, st);
    check("lru_ld000_miss", 32'(st != 0), 32'd1);
    check("lru_ld000_rdata", rd, 32'h60);
    access(1'b0, 32'h100, 4'h0, 32'h0, rd, st);
    check("lru_ld100_miss", 32'(st != 0), 32'd1);
    access(1'b0, 32'h000, 4'h0, 32'h0, rd, st);
    check("lru_ld000_hit", 32'(st), 32'd0);
    access(1'b0, 32'h200, 4'h0, 32'h0, rd, st);
    check("lru_ld200_miss", 32'(st != 0), 32'd1);
    check("lru_ld200_rdata", rd, 32'hE0);
    access(1'b0, 32'h000, 4'h0, 32'h0, rd, st);
    check("lru_ld000_hit2", 32'(st), 32'd0);
    access(1'b0, 32'h100, 4'h0, 32'h0, rd, st);
    check("lru_ld100_evict", 32'(st != 0), 32'd1);
    check("lru_ld100_rdata", rd, 32'hA0);

    // Reset during the second fill beat
    do_reset();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300;
    n = 0;
    for (int c = 0; c < 50 && n < 2; c++) begin
      @(negedge clk);
      if (mem_rvalid) n = n + 1;
    end
    check("mid_beats", 32'(n), 32'd2);
    rst = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_stall", 32'(stall), 32'd0);
    check("mid_rst_memvalid", 32'(mem_req_valid), 32'd0);
    rst = 1'b1;
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(negedge clk);
    check("mid_stray_stall", 32'(stall), 32'd0);
    check("mid_stray_memvalid", 32'(mem_req_valid), 32'd0);
    @(posedge clk);
    #1;
    fill_log.delete();
    access(1'b0, 32'h100, 4'h0, 32'h0, rd, st);
    check("mid_refill_miss", 32'(st != 0), 32'd1);
    check("mid_refill_nfill", 32'(fill_log.size()), 32'd4);
    check("mid_refill_rdata", rd, 32'hA0);

    // Backpressure: ready toggles every cycle during a fill
    fill_log.delete();
    viol = 0;
    ready_mode = 2;
    access(1'b0, 32'h500, 4'h0, 32'h0, rd, st);
    ready_mode = 0;
    check("bp_stable_viol", 32'(viol), 32'd0);
    check("bp_nfill", 32'(fill_log.size()), 32'd4);
    check("bp_faddr3", (fill_log.size() > 3) ? fill_log[3] : 32'hFFFF_FFFF, 32'h50C);
    check("bp_rdata", rd, 32'h1A0);
    access(1'b0, 32'h50C, 4'h0, 32'h0, rd, st);
    check("bp_hit_stalls", 32'(st), 32'd0);
    check("bp_hit_rdata", rd, 32'h1A3);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/dcache_wt.md
Name: dcache_wt

Overview:
- Parametrised, set-associative, write-through, no-write-allocate data cache.
- Replaces the direct combinational data-memory path between the ALU/register file and a slower backing memory.
- The core side is single-cycle on a read hit; misses and all writes stall the core while a handshake-based memory port services them.
- This is the next-generation memory path for the pipelined/multicycle cores; depth, associativity and line size are generalised.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width. Fixed at 32; byte enables are 4 bits.
- NUM_SETS, 16, number of sets. Power of 2, ≥2.
- WAYS, 2, associativity. 1 or 2 only.
- LINE_WORDS, 4, words per line. Power of 2, ≥1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- req_valid  in  1  core access request; held stable while stall=1.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  byte address, word-aligned.
- req_be  in  4  store byte enables.
- req_wdata  in  DATA_WIDTH  store data.
- rdata  out  DATA_WIDTH  load data; valid when req_valid & !req_we & !stall.
- stall  out  1  core must hold its request and freeze the PC.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts the request this cycle.
- mem_we  out  1  memory write (1) or line-fill read (0).
- mem_addr  out  ADDR_WIDTH  word address of the beat (byte address, word-aligned).
- mem_be  out  4  write byte enables.
- mem_wdata  out  DATA_WIDTH  write data.
- mem_rvalid  in  1  fill-beat data valid.
- mem_rdata  in  DATA_WIDTH  fill-beat data.

Behaviour:
- Address split:
  - offset = addr[1:0] (ignored).
  - word = next log2(LINE_WORDS) bits.
  - index = next log2(NUM_SETS) bits.
  - tag = the remaining bits.
- Storage per way: valid[NUM_SETS], tag[NUM_SETS], data[NUM_SETS][LINE_WORDS].
- Storage per set: one lru bit, used only when WAYS=2.
- Lookup is combinational. hit = any way with valid & tag match at index.
- Reset (rst=0 at a clock edge):
  - All valid and lru bits cleared; state goes to IDLE.
  - mem_req_valid=0, mem_we=0, stall=0 in the following cycle; rdata=0 when not hitting.
  - Data and tag arrays are not cleared.
  - Reset mid-fill or mid-write abandons the transfer. Late mem_rvalid beats after reset are ignored.
- FSM states: IDLE, FILL, WRITE.
- IDLE:
  - No req_valid: stall=0.
  - Load hit: stall=0; rdata = matching word, same cycle (0 extra latency). The lru bit of the set points to the way not hit.
  - Load miss: stall=1.
    - Victim: invalid way 0 first, then invalid way 1, else the lru way.
    - Latch victim, index, tag and line base; beat counter = 0; go to FILL.
  - Store (hit or miss): stall=1.
    - On a hit, the cached word is updated per req_be on this edge and lru is updated.
    - Go to WRITE.
- FILL:
  - Request phase: mem_req_valid=1, mem_we=0, mem_addr = line base + counter×4.
  - Each accepted request (mem_req_valid & mem_req_ready) increments the issue counter.
  - Each mem_rvalid writes mem_rdata into victim word[recv counter] and increments the recv counter.
  - Requests stop after LINE_WORDS accepts.
  - When the recv counter reaches LINE_WORDS: set valid and tag for the victim, go to IDLE.
  - The lookup then hits and releases stall in that IDLE cycle (load-miss latency = fill time + 1).
  - mem_rvalid is only honoured in FILL; beats arrive in request order.
- WRITE:
  - mem_req_valid=1, mem_we=1, mem_addr=req_addr, mem_be=req_be, mem_wdata=req_wdata.
  - Stall stays 1 until mem_req_ready.
  - On the handshake: go to IDLE with stall=0 in that same cycle (acknowledges the store).
  - Write miss allocates nothing.
- Requests: mem_req_valid, once asserted, stays high with stable fields until accepted.
- Wrap-around: the issue and recv counters are log2(LINE_WORDS)+1 bits wide, so LINE_WORDS itself is representable. There is no wrap within a line; fills always start at word 0.
- WAYS=1: lru is unused and the victim is always way 0.
- Core contract: a back-to-back request in the IDLE cycle after a completed access is legal. The core never changes its request while stall=1.

Decomposition:
- Package dcache_pkg holds:
  - the state enum (IDLE, FILL, WRITE);
  - localparam helpers for WORD_BITS, INDEX_BITS and TAG_BITS as functions of the parameters;
  - a line_addr_t struct {tag, index, word}.
- Sub-module dcache_way: one way's valid/tag/data arrays, with:
  - combinational tag compare and read port;
  - a synchronous fill-write port and a byte-enabled store-write port;
  - valid clear on reset.
- Instantiated WAYS times by a generate loop.

Test Plan:
- Cold load: reset, then load 0x0000_0100 with a memory returning word 0xA0+i at 0x100+4i, ready=1, 1-cycle rvalid.
  - Expect 4 fill requests at 0x100, 0x104, 0x108, 0x10C.
  - rdata=0xA0 once stall drops.
  - A following load of 0x104 hits with stall=0 and rdata=0xA1.
- Store hit: after the above, store 0x104 with be=4'b0011, wdata=0xDEAD_BEEF, ready delayed 3 cycles.
  - stall stays 1 for 3 cycles, with mem_we=1 and mem_be=0011.
  - A subsequent load of 0x104 hits with rdata=0x0000_BEEF.
- Store miss: store 0x0000_2000.
  - One memory write, no fill.
  - A subsequent load of 0x2000 misses (fill observed).
- LRU (WAYS=2, NUM_SETS=16, LINE_WORDS=4):
  - Load 0x000, then 0x100 (same set), then 0x000 again (hit), then 0x200.
  - The 0x100 line is evicted: load 0x000 hits, load 0x100 misses.
- Reset mid-fill: assert rst=0 during the 2nd fill beat and release.
  - stall=0 and mem_req_valid=0 after reset.
  - A stray mem_rvalid is ignored.
  - Load 0x100 misses and refills.
- Backpressure: mem_req_ready toggles 0/1 every cycle during a fill.
  - mem_addr and mem_req_valid stay stable while unaccepted.
  - The line completes with correct data.
